// File: rtl/adc_sample_averager.sv
// adc_sample_averager: power-of-two window averager with round-half-up result,
// one-entry valid/ready output slot and sticky overrun / saturating drop count.
module adc_sample_averager #(
  parameter int ADC_WIDTH      = 16,
  parameter int MAX_LOG2       = 7,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic [ADC_WIDTH-1:0]      sample_in,
  input  logic                      sample_valid,
  input  logic [2:0]                avg_log2,
  input  logic                      clear,
  output logic [ADC_WIDTH-1:0]      avg_data,
  output logic                      avg_valid,
  input  logic                      avg_ready,
  output logic                      overrun,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic [MAX_LOG2:0]         fill_count
);
  localparam int AW = ADC_WIDTH + MAX_LOG2;
  localparam int FW = MAX_LOG2 + 1;
  logic [AW-1:0]             acc_q, acc_d;
  logic [FW-1:0]             fill_q, fill_d;
  logic [2:0]                l_q, l_d;
  logic [ADC_WIDTH-1:0]      data_q, data_d;
  logic                      valid_q, valid_d;
  logic                      ovr_q, ovr_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  logic [2:0]                l_clamp, l_cur;
  logic [FW-1:0]             fill_inc, window;
  logic [AW-1:0]             sum, half, rounded, shifted;
  logic                      last, res_v, load, drop;
  always_comb begin
    l_clamp  = (avg_log2 > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : avg_log2;
    // The first sample of a window uses the live exponent; later ones the latched copy
    l_cur    = (fill_q == '0) ? l_clamp : l_q;
    fill_inc = fill_q + FW'(1);
    window   = FW'(1) << l_cur;
    last     = sample_valid && (fill_inc == window);
    sum      = acc_q + AW'(sample_in);
    half     = (l_cur == 3'd0) ? '0 : (AW'(1) << (l_cur - 3'd1));
    rounded  = sum + half;
    shifted  = rounded >> l_cur;
    res_v    = !clear && last;
    load     = res_v && (!valid_q || avg_ready);
    drop     = res_v && valid_q && !avg_ready;
    acc_d    = (clear || last) ? '0 : sample_valid ? sum : acc_q;
    fill_d   = (clear || last) ? '0 : sample_valid ? fill_inc : fill_q;
    l_d      = (!clear && sample_valid && fill_q == '0) ? l_clamp : l_q;
    data_d   = load ? shifted[ADC_WIDTH-1:0] : data_q;
    valid_d  = clear ? 1'b0 : load ? 1'b1 : (valid_q && avg_ready) ? 1'b0 : valid_q;
    ovr_d    = clear ? 1'b0 : (drop || ovr_q);
    drop_d   = clear ? '0 : (drop && drop_q != '1) ? drop_q + DROP_CNT_WIDTH'(1) : drop_q;
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q   <= '0;
      fill_q  <= '0;
      l_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      l_q     <= l_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      drop_q  <= drop_d;
    end
  end
  assign avg_data   = data_q;
  assign avg_valid  = valid_q;
  assign overrun    = ovr_q;
  assign drop_count = drop_q;
  assign fill_count = fill_q;
endmodule

// File: tb/tb_adc_sample_averager.sv
// tb_adc_sample_averager: directed and random stimulus checked against a window-list model.
module tb_adc_sample_averager;
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [2:0]  avg_log2 = '0;
  logic        clear = 1'b0;
  logic [15:0] avg_data;
  logic        avg_valid;
  logic        avg_ready = 1'b0;
  logic        overrun;
  logic [7:0]  drop_count;
  logic [7:0]  fill_count;
  int n_chk = 0;
  int n_fail = 0;
  int unsigned win[$];
  int          m_l;
  logic [15:0] m_data;
  bit          m_valid, m_ovr;
  int          m_drop;
  adc_sample_averager dut (
    .clk(clk), .aresetn(aresetn), .sample_in(sample_in), .sample_valid(sample_valid),
    .avg_log2(avg_log2), .clear(clear), .avg_data(avg_data), .avg_valid(avg_valid),
    .avg_ready(avg_ready), .overrun(overrun), .drop_count(drop_count), .fill_count(fill_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".valid"}, 32'(avg_valid), 32'(m_valid));
    chk({tag, ".data"}, 32'(avg_data), 32'(m_data));
    chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".drop"}, 32'(drop_count), 32'(m_drop));
    chk({tag, ".fill"}, 32'(fill_count), 32'(win.size()));
  endtask
  task automatic model_reset();
    win.delete();
    m_l = 0; m_data = '0; m_valid = 0; m_ovr = 0; m_drop = 0;
  endtask
  // Behavioural model: collect the window as a list, average it when it is full
  task automatic model_step(input bit sv, input logic [15:0] s, input logic [2:0] lg,
                            input bit clr, input bit rdy);
    bit res = 0;
    longint sum;
    logic [15:0] r = '0;
    if (clr) begin
      win.delete(); m_valid = 0; m_ovr = 0; m_drop = 0;
      return;
    end
    if (sv) begin
      if (win.size() == 0) m_l = (lg > 7) ? 7 : int'(lg);
      win.push_back(int'(s));
      if (win.size() == (1 << m_l)) begin
        sum = 0;
        foreach (win[i]) sum += win[i];
        sum = (sum + ((m_l > 0) ? (longint'(1) << (m_l - 1)) : 0)) / (longint'(1) << m_l);
        r = sum[15:0];
        res = 1;
        win.delete();
      end
    end
    if (res) begin
      if (!m_valid || rdy) begin m_data = r; m_valid = 1; end
      else begin m_ovr = 1; if (m_drop < 255) m_drop++; end
    end else if (m_valid && rdy) m_valid = 0;
  endtask
  task automatic tick(input bit sv, input logic [15:0] s, input logic [2:0] lg,
                      input bit clr, input bit rdy);
    sample_valid = sv; sample_in = s; avg_log2 = lg; clear = clr; avg_ready = rdy;
    model_step(sv, s, lg, clr, rdy);
    @(posedge clk);
    #1;
    chk_all("tick");
  endtask
  task automatic pulse_reset();
    #2;
    aresetn = 0;
    sample_valid = 0; clear = 0; avg_ready = 0;
    model_reset();
    #1;
    chk_all("reset");
    @(posedge clk);
    #1;
    chk_all("reset_hold");
    aresetn = 1;
  endtask
  initial begin
    model_reset();
    #1;
    chk_all("por");
    @(posedge clk); #1;
    chk_all("por2");
    aresetn = 1;
    // L=2 window of 100,200,300,401 -> 250
    tick(1, 100, 2, 0, 0);
    tick(1, 200, 2, 0, 0);
    tick(1, 300, 2, 0, 0);
    chk("l2_not_yet", 32'(avg_valid), 0);
    tick(1, 401, 2, 0, 0);
    chk("l2_valid", 32'(avg_valid), 1);
    chk("l2_avg", 32'(avg_data), 250);
    tick(0, 0, 2, 0, 1);
    // L=4 full-scale and alternating patterns
    for (int i = 0; i < 16; i++) tick(1, 16'hFFFF, 4, 0, 1);
    chk("l4_ffff", 32'(avg_data), 32'hFFFF);
    for (int i = 0; i < 16; i++) tick(1, (i % 2) ? 16'h5555 : 16'hAAAA, 4, 0, 1);
    chk("l4_alt", 32'(avg_data), 32'h8000);
    // L=0 pass-through with drain and refill
    tick(0, 0, 0, 0, 1);
    tick(1, 16'h00F0, 0, 0, 1);
    chk("l0_a", 32'(avg_data), 32'h00F0);
    tick(1, 16'h1234, 0, 0, 1);
    chk("l0_b", 32'(avg_data), 32'h1234);
    chk("l0_valid", 32'(avg_valid), 1);
    tick(0, 0, 0, 0, 1);
    // L=1 with a stalled consumer
    for (int i = 0; i < 6; i++) tick(1, 16'(10 * (i + 1)), 1, 0, 0);
    chk("ovr_data", 32'(avg_data), 15);
    chk("ovr_drop", 32'(drop_count), 2);
    chk("ovr_flag", 32'(overrun), 1);
    tick(0, 0, 1, 0, 1);
    chk("ovr_drain", 32'(avg_valid), 0);
    chk("ovr_sticky", 32'(overrun), 1);
    tick(0, 0, 1, 1, 0);
    chk("ovr_clear", 32'(overrun), 0);
    // Exponent change mid-window takes effect next window
    tick(1, 10, 2, 0, 1);
    tick(1, 20, 2, 0, 1);
    tick(1, 30, 3, 0, 1);
    tick(1, 40, 3, 0, 1);
    chk("lchg_valid", 32'(avg_valid), 1);
    chk("lchg_avg", 32'(avg_data), 25);
    for (int i = 0; i < 7; i++) tick(1, 16'(i), 3, 0, 1);
    chk("l3_fill7", 32'(fill_count), 7);
    tick(1, 16'd7, 3, 0, 1);
    chk("l3_avg", 32'(avg_data), 4);
    // Clear on the third sample
    tick(1, 1000, 2, 0, 1);
    tick(1, 1000, 2, 0, 1);
    tick(1, 1000, 2, 1, 1);
    chk("clr_fill", 32'(fill_count), 0);
    chk("clr_valid", 32'(avg_valid), 0);
    for (int i = 0; i < 4; i++) tick(1, 16'(8 * i), 2, 0, 0);
    chk("clr_avg", 32'(avg_data), 12);
    tick(0, 0, 2, 0, 1);
    // Reset mid-window
    tick(1, 5000, 2, 0, 1);
    tick(1, 5000, 2, 0, 1);
    pulse_reset();
    for (int i = 0; i < 4; i++) tick(1, 16'(2 + i), 2, 0, 0);
    chk("rst_avg", 32'(avg_data), 4);
    // Random traffic
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 9) < 7, 16'($urandom),
           ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 3)),
           $urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
